tone_freq_meter: RTL and testbench

Measures the frequency of an incoming square-wave tone in the SOUND path, such as the 4 Hz toggling source or an audio-rate oscillator. It counts rising edges of the input over a fixed gate time derived from the system clock. It publishes the scaled frequency in Hz once per gate, together with a one-cycle valid strobe, an overflow flag and a signal-present flag. Its consumers are the display/LED logic and the self-check for the tone generators.

---
 rtl/tone_freq_meter.sv | 110 +++++++++++
 tb/tb_tone_freq_meter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tone_freq_meter.sv
// Tone frequency meter: counts synchronized rising edges of iSIG over a fixed gate and
// reports edges_per_gate * GATE_DIV (Hz) once per gate with valid/overflow/present flags.
module tone_freq_meter #(
   parameter int unsigned CLK_HZ   = 50000000,
   parameter int unsigned GATE_DIV = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                                 iCLK,
   input  logic                                 iRST,
   input  logic                                 iSIG,
   output logic [CNT_W+$clog2(GATE_DIV)-1:0]    oFREQ,
   output logic                                 oVALID,
   output logic                                 oOVF,
   output logic                                 oPRESENT
);

   localparam int unsigned GATE_LEN = CLK_HZ / GATE_DIV;
   localparam int unsigned SHIFT    = $clog2(GATE_DIV);
   localparam int unsigned FREQ_W   = CNT_W + SHIFT;
   localparam int unsigned GC_W     = (GATE_LEN > 1) ? $clog2(GATE_LEN) : 1;

   localparam logic [GC_W-1:0]  GC_LAST = GC_W'(GATE_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {StDiscard, StCount} state_t;

   logic              r_sync1, r_sync2, r_prev;
   logic              w_edge, w_term, w_sat;
   logic [GC_W-1:0]   r_gate_cnt, w_gate_nxt;
   logic [CNT_W-1:0]  r_edge_cnt, w_edge_nxt, w_cnt_inc;
   logic              r_ovf, w_ovf_nxt, w_ovf_inc;
   logic [FREQ_W-1:0] r_freq, w_freq_nxt;
   logic              r_valid, w_valid_nxt;
   logic              r_ovf_out, w_ovf_out_nxt;
   logic              r_present, w_present_nxt;
   state_t            r_state, w_state_nxt;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= iSIG;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_edge = r_sync2 & ~r_prev;
   assign w_term = (r_gate_cnt == GC_LAST);
   assign w_sat  = (r_edge_cnt == CNT_MAX);

   // Count as seen in this cycle, so an edge on the terminal cycle lands in the closing gate.
   assign w_cnt_inc = (w_edge && !w_sat) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
   assign w_ovf_inc = r_ovf | (w_edge & w_sat);

   always_comb begin
      w_state_nxt   = r_state;
      w_gate_nxt    = w_term ? '0 : r_gate_cnt + GC_W'(1);
      w_edge_nxt    = w_term ? '0 : w_cnt_inc;
      w_ovf_nxt     = w_term ? 1'b0 : w_ovf_inc;
      w_freq_nxt    = r_freq;
      w_valid_nxt   = 1'b0;
      w_ovf_out_nxt = r_ovf_out;
      w_present_nxt = r_present;
      unique case (r_state)
         StDiscard: begin
            if (w_term) w_state_nxt = StCount;
         end
         StCount: begin
            if (w_term) begin
               w_freq_nxt    = FREQ_W'(w_cnt_inc) << SHIFT;
               w_valid_nxt   = 1'b1;
               w_ovf_out_nxt = w_ovf_inc;
               w_present_nxt = (w_cnt_inc != '0);
            end
         end
         default: w_state_nxt = StDiscard;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state    <= StDiscard;
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
         r_ovf      <= 1'b0;
         r_freq     <= '0;
         r_valid    <= 1'b0;
         r_ovf_out  <= 1'b0;
         r_present  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gate_cnt <= w_gate_nxt;
         r_edge_cnt <= w_edge_nxt;
         r_ovf      <= w_ovf_nxt;
         r_freq     <= w_freq_nxt;
         r_valid    <= w_valid_nxt;
         r_ovf_out  <= w_ovf_out_nxt;
         r_present  <= w_present_nxt;
      end
   end

   assign oFREQ    = r_freq;
   assign oVALID   = r_valid;
   assign oOVF     = r_ovf_out;
   assign oPRESENT = r_present;

endmodule

// File: tb/tb_tone_freq_meter.sv
// Directed bench for tone_freq_meter: GATE_LEN=250, one CNT_W=8 and one CNT_W=4 instance
// sharing stimulus. Cycle 0 is the first cycle with iRST low.
module tb_tone_freq_meter;

   localparam int M_STEADY = 0;
   localparam int M_IDLE   = 1;
   localparam int M_HIRST  = 2;
   localparam int M_SAT    = 3;
   localparam int M_WRAP   = 4;

   logic       clk = 1'b0;
   logic       rst, sig;
   logic [9:0] freq_a;
   logic       valid_a, ovf_a, pres_a;
   logic [5:0] freq_b;
   logic       valid_b, ovf_b, pres_b;

   int mode, cyc, n_cmp, n_err, n_valid_a, n_valid_b;

   always #5 clk = ~clk;

   tone_freq_meter #(.CLK_HZ(1000), .GATE_DIV(4), .CNT_W(8)) u_dut_a (
      .iCLK(clk), .iRST(rst), .iSIG(sig),
      .oFREQ(freq_a), .oVALID(valid_a), .oOVF(ovf_a), .oPRESENT(pres_a)
   );

   tone_freq_meter #(.CLK_HZ(1000), .GATE_DIV(4), .CNT_W(4)) u_dut_b (
      .iCLK(clk), .iRST(rst), .iSIG(sig),
      .oFREQ(freq_b), .oVALID(valid_b), .oOVF(ovf_b), .oPRESENT(pres_b)
   );

   // Input driven in cycle c is counted as an edge in cycle c+2.
   function automatic logic sig_of(int m, int c);
      case (m)
         M_STEADY: return (c % 10) >= 5;
         M_IDLE:   return 1'b0;
         M_HIRST: begin
            if (c < 40) return 1'b1;
            else if (c < 60) return 1'b0;
            else return ((c - 60) % 20) < 10;
         end
         M_SAT: begin
            if (c < 496) return (c % 4) >= 2;
            else if (c < 498) return 1'b0;
            else return ((c - 498) % 50) >= 25;
         end
         M_WRAP: return (c >= 497 && c < 499) || (c >= 600 && c < 602) ||
                        (c >= 748 && c < 750) || (c >= 800 && c < 802);
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      sig = sig_of(mode, cyc);
      if (valid_a) n_valid_a++;
      if (valid_b) n_valid_b++;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic start(input int m);
      mode = m;
      rst  = 1'b1;
      cyc  = -3;
      sig  = sig_of(m, cyc);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      sig = sig_of(m, 0);
      n_valid_a = 0;
      n_valid_b = 0;
   endtask

   task automatic check_a(input string tag, input int f, input logic o, input logic p);
      check({tag, "_valid"}, valid_a, 1);
      check({tag, "_freq"}, freq_a, f);
      check({tag, "_ovf"}, ovf_a, o);
      check({tag, "_present"}, pres_a, p);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      // Steady period-10 tone: 25 edges/gate -> 100 Hz.
      start(M_STEADY);
      check("rst_freq", freq_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_present", pres_a, 0);
      run_to(499);
      check("steady_no_early_valid", n_valid_a, 0);
      step();
      check_a("steady_500", 100, 1'b0, 1'b1);
      step();
      check("steady_501_valid", valid_a, 0);
      check("steady_501_hold", freq_a, 100);
      n_valid_a = 0;
      run_to(749);
      check("steady_gap_valid", n_valid_a, 0);
      step();
      check_a("steady_750", 100, 1'b0, 1'b1);
      run_to(1000);
      check_a("steady_1000", 100, 1'b0, 1'b1);

      // No input.
      start(M_IDLE);
      run_to(500);
      check_a("idle_500", 0, 1'b0, 1'b0);
      run_to(750);
      check_a("idle_750", 0, 1'b0, 1'b0);

      // High through reset; the false edge falls in the discarded gate. Rises 260..480 -> 12.
      start(M_HIRST);
      run_to(499);
      check("hirst_no_early_valid", n_valid_a, 0);
      step();
      check_a("hirst_500", 48, 1'b0, 1'b1);

      // Period-4 tone saturates the 4-bit counter (62 edges), then 5 edges at period 50.
      start(M_SAT);
      run_to(500);
      check("sat_b_valid", valid_b, 1);
      check("sat_b_freq", freq_b, 60);
      check("sat_b_ovf", ovf_b, 1);
      check("sat_b_present", pres_b, 1);
      check_a("sat_wide_500", 248, 1'b0, 1'b1);
      run_to(750);
      check("sat_b2_valid", valid_b, 1);
      check("sat_b2_freq", freq_b, 20);
      check("sat_b2_ovf", ovf_b, 0);
      check("sat_b2_present", pres_b, 1);

      // Edge counted on terminal cycle 499 and on wrap cycle 750.
      start(M_WRAP);
      run_to(500);
      check_a("wrap_term_500", 4, 1'b0, 1'b1);
      run_to(750);
      check_a("wrap_mid_750", 4, 1'b0, 1'b1);
      run_to(1000);
      check_a("wrap_next_1000", 8, 1'b0, 1'b1);

      // One-cycle reset at cycle 620 discards the partial gate.
      start(M_STEADY);
      run_to(620);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_freq", freq_a, 0);
      check("midrst_valid", valid_a, 0);
      check("midrst_ovf", ovf_a, 0);
      check("midrst_present", pres_a, 0);
      n_valid_a = 0;
      run_to(1120);
      check("midrst_no_valid", n_valid_a, 0);
      step();
      check_a("midrst_1121", 100, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
